// File: rtl/jb_axis_iq_frame_packer.sv
// Frames an always-valid {q,i} sample stream into AXIS packets (tlast on length,
// user-ID change or idle timeout) and buffers them for a back-pressurable consumer.
module jb_axis_iq_frame_packer #(
    parameter int unsigned DATA_BW      = 32,
    parameter int unsigned USR_ID_BW    = 2,
    parameter int unsigned FRAME_LEN    = 4,
    parameter int unsigned FRAME_LEN_BW = 2,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned TIMEOUT      = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clk_en,
    input  logic                 s_tvalid,
    input  logic [DATA_BW-1:0]   s_tdata,
    input  logic [USR_ID_BW-1:0] s_tuser,
    output logic                 s_tready,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [DATA_BW-1:0]   m_tdata,
    output logic [USR_ID_BW-1:0] m_tuser,
    output logic                 m_tlast,
    output logic                 ovf_err,
    output logic [15:0]          drop_cnt,
    input  logic                 clr_err
);

    localparam int unsigned PTR_BW = $clog2(FIFO_DEPTH);
    localparam int unsigned TMR_BW = $clog2(TIMEOUT);
    localparam int unsigned CNT_BW = 16;

    typedef struct packed {
        logic                 last;
        logic [USR_ID_BW-1:0] user;
        logic [DATA_BW-1:0]   data;
    } word_t;

    logic [DATA_BW-1:0]      h_data;
    logic [USR_ID_BW-1:0]    h_user;
    logic                    hv;
    logic [FRAME_LEN_BW-1:0] frame_cnt;
    logic [TMR_BW-1:0]       idle_tmr;

    // The output register is the FIFO head, so the array only ever holds DEPTH-1 words.
    word_t                   mem [FIFO_DEPTH];
    logic [PTR_BW-1:0]       rd_ptr;
    logic [PTR_BW-1:0]       wr_ptr;
    logic [PTR_BW-1:0]       mem_cnt;

    logic  accept;
    logic  flush;
    logic  commit;
    word_t c_word;
    logic  pop;
    logic  full;
    logic  wr;
    logic  drop;
    logic  mem_rd;
    logic  mem_wr;
    logic  bypass;

    assign s_tready = 1'b1;

    // Commit / FIFO steering decisions for this cycle.
    always_comb begin
        accept      = clk_en & s_tvalid;
        flush       = clk_en & hv & ~s_tvalid & (idle_tmr == TMR_BW'(TIMEOUT - 1));
        commit      = (accept & hv) | flush;
        c_word.data = h_data;
        c_word.user = h_user;
        c_word.last = flush | (frame_cnt == FRAME_LEN_BW'(FRAME_LEN - 1)) | (s_tuser != h_user);
        pop         = clk_en & m_tvalid & m_tready;
        full        = m_tvalid & (mem_cnt == PTR_BW'(FIFO_DEPTH - 1));
        wr          = commit & (~full | pop);
        drop        = commit & full & ~pop;
        mem_rd      = pop & (mem_cnt != '0);
        bypass      = wr & (~m_tvalid | (pop & (mem_cnt == '0)));
        mem_wr      = wr & ~bypass;
    end

    // Hold register, in-frame counter and idle timer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_data    <= '0;
            h_user    <= '0;
            hv        <= 1'b0;
            frame_cnt <= '0;
            idle_tmr  <= '0;
        end else if (clk_en) begin
            if (accept) begin
                h_data <= s_tdata;
                h_user <= s_tuser;
                hv     <= 1'b1;
            end else if (flush) begin
                hv <= 1'b0;
            end
            if (accept || !hv || flush) begin
                idle_tmr <= '0;
            end else begin
                idle_tmr <= idle_tmr + TMR_BW'(1);
            end
            // Dropped words still advance framing so later frames stay aligned.
            if (commit) begin
                frame_cnt <= c_word.last ? '0 : frame_cnt + FRAME_LEN_BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= c_word;
        end
    end

    // Show-ahead output register fed from the array head or directly from a commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= '0;
            m_tlast  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            mem_cnt  <= '0;
        end else begin
            if (mem_rd) begin
                m_tvalid <= 1'b1;
                m_tdata  <= mem[rd_ptr].data;
                m_tuser  <= mem[rd_ptr].user;
                m_tlast  <= mem[rd_ptr].last;
                rd_ptr   <= rd_ptr + PTR_BW'(1);
            end else if (bypass) begin
                m_tvalid <= 1'b1;
                m_tdata  <= c_word.data;
                m_tuser  <= c_word.user;
                m_tlast  <= c_word.last;
            end else if (pop) begin
                m_tvalid <= 1'b0;
            end
            if (mem_wr) begin
                wr_ptr <= wr_ptr + PTR_BW'(1);
            end
            case ({mem_wr, mem_rd})
                2'b10:   mem_cnt <= mem_cnt + PTR_BW'(1);
                2'b01:   mem_cnt <= mem_cnt - PTR_BW'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; clear wins over a drop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_err  <= 1'b0;
            drop_cnt <= '0;
        end else if (clk_en) begin
            if (clr_err) begin
                ovf_err  <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                ovf_err <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jb_axis_iq_frame_packer.sv
// Directed bench for jb_axis_iq_frame_packer: framing, timeout flush, overflow,
// error clear, clock-enable freeze and asynchronous reset.
module tb_jb_axis_iq_frame_packer;

    logic        clk;
    logic        resetn;
    logic        clk_en;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic [1:0]  s_tuser;
    logic        s_tready;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [1:0]  m_tuser;
    logic        m_tlast;
    logic        ovf_err;
    logic [15:0] drop_cnt;
    logic        clr_err;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  u;
        logic        l;
    } word_t;

    word_t got[$];
    int    tests = 0;
    int    fails = 0;

    jb_axis_iq_frame_packer #(
        .DATA_BW(32), .USR_ID_BW(2), .FRAME_LEN(4), .FRAME_LEN_BW(2),
        .FIFO_DEPTH(8), .TIMEOUT(8)
    ) dut (
        .clk(clk), .resetn(resetn), .clk_en(clk_en),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .ovf_err(ovf_err), .drop_cnt(drop_cnt), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake; inputs are stable from negedge to the next posedge.
    always @(negedge clk) begin
        if (resetn && clk_en && m_tvalid && m_tready)
            got.push_back({m_tdata, m_tuser, m_tlast});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] u);
        s_tvalid = v;
        s_tdata  = d;
        s_tuser  = u;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        clk_en   = 1'b1;
        clr_err  = 1'b0;
        m_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0; clk_en = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0;
        m_tready = 1'b0; clr_err = 1'b0;
        #1;
        tests++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast, ovf_err, drop_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h u=%h l=%b ovf=%b drop=%0d, want all 0",
                     m_tvalid, m_tdata, m_tuser, m_tlast, ovf_err, drop_cnt);
        end
        tests++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_s_tready: got %b want 1", s_tready);
        end
        do_reset();
    endtask

    task automatic test_continuous();
        word_t e;
        do_reset();
        m_tready = 1'b1;
        for (int k = 1; k <= 8; k++) drive(1'b1, 32'(k), 2'd0);
        for (int k = 0; k < 12; k++) drive(1'b0, '0, 2'd0);
        tests++;
        if (got.size() != 8) begin
            fails++;
            $display("FAIL cont_count: got %0d words want 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            e = {32'(i + 1), 2'd0, (i == 3 || i == 7)};
            tests++;
            if (i >= got.size() || got[i] !== e) begin
                fails++;
                $display("FAIL cont_word[%0d]: got %h want %h", i,
                         (i < got.size()) ? got[i] : '0, e);
            end
        end
    endtask

    task automatic test_user_change();
        word_t e [4];
        do_reset();
        m_tready = 1'b1;
        e[0] = {32'd1, 2'd1, 1'b0};
        e[1] = {32'd2, 2'd1, 1'b0};
        e[2] = {32'd3, 2'd1, 1'b1};
        e[3] = {32'd4, 2'd2, 1'b1};
        for (int k = 1; k <= 3; k++) drive(1'b1, 32'(k), 2'd1);
        drive(1'b1, 32'd4, 2'd2);
        for (int k = 0; k < 12; k++) drive(1'b0, '0, 2'd0);
        tests++;
        if (got.size() != 4) begin
            fails++;
            $display("FAIL uid_count: got %0d words want 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== e[i]) begin
                fails++;
                $display("FAIL uid_word[%0d]: got %h want %h", i,
                         (i < got.size()) ? got[i] : '0, e[i]);
            end
        end
    endtask

    task automatic test_timeout_latency();
        logic exp_v;
        do_reset();
        drive(1'b1, 32'h0000_A5A5, 2'd0);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, '0, 2'd0);
            exp_v = (k == 8);
            tests++;
            if (m_tvalid !== exp_v) begin
                fails++;
                $display("FAIL tmo_valid[idle %0d]: got %b want %b", k, m_tvalid, exp_v);
            end
        end
        tests++;
        if ({m_tdata, m_tuser, m_tlast} !== {32'h0000_A5A5, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL tmo_word: got d=%h u=%h l=%b want d=0000a5a5 u=0 l=1",
                     m_tdata, m_tuser, m_tlast);
        end
        m_tready = 1'b1;
        drive(1'b0, '0, 2'd0);
        tests++;
        if (m_tvalid !== 1'b0 || got.size() != 1) begin
            fails++;
            $display("FAIL tmo_single: got valid=%b words=%0d want valid=0 words=1",
                     m_tvalid, got.size());
        end
    endtask

    task automatic test_overflow();
        word_t e;
        do_reset();
        for (int k = 1; k <= 12; k++) drive(1'b1, 32'(k), 2'd0);
        tests++;
        if (ovf_err !== 1'b1 || drop_cnt !== 16'd3) begin
            fails++;
            $display("FAIL ovf_flags: got ovf=%b drop=%0d want ovf=1 drop=3", ovf_err, drop_cnt);
        end
        drive(1'b0, '0, 2'd0);
        tests++;
        if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, 32'd1, 1'b0}) begin
            fails++;
            $display("FAIL ovf_stall_stable: got v=%b d=%h l=%b want v=1 d=1 l=0",
                     m_tvalid, m_tdata, m_tlast);
        end
        m_tready = 1'b1;
        for (int k = 0; k < 14; k++) drive(1'b0, '0, 2'd0);
        tests++;
        if (got.size() != 9) begin
            fails++;
            $display("FAIL ovf_count: got %0d words want 9", got.size());
        end
        for (int i = 0; i < 9; i++) begin
            e = {(i < 8) ? 32'(i + 1) : 32'd12, 2'd0, (i == 3 || i == 7 || i == 8)};
            tests++;
            if (i >= got.size() || got[i] !== e) begin
                fails++;
                $display("FAIL ovf_word[%0d]: got %h want %h", i,
                         (i < got.size()) ? got[i] : '0, e);
            end
        end
    endtask

    task automatic test_clr_err();
        do_reset();
        for (int k = 1; k <= 10; k++) drive(1'b1, 32'(k), 2'd0);
        tests++;
        if (ovf_err !== 1'b1 || drop_cnt !== 16'd1) begin
            fails++;
            $display("FAIL clr_pre: got ovf=%b drop=%0d want ovf=1 drop=1", ovf_err, drop_cnt);
        end
        clr_err = 1'b1;
        drive(1'b1, 32'd11, 2'd0);
        clr_err = 1'b0;
        tests++;
        if (ovf_err !== 1'b0 || drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL clr_priority: got ovf=%b drop=%0d want ovf=0 drop=0", ovf_err, drop_cnt);
        end
        drive(1'b1, 32'd12, 2'd0);
        tests++;
        if (ovf_err !== 1'b1 || drop_cnt !== 16'd1) begin
            fails++;
            $display("FAIL clr_after: got ovf=%b drop=%0d want ovf=1 drop=1", ovf_err, drop_cnt);
        end
    endtask

    task automatic test_clk_en();
        do_reset();
        drive(1'b1, 32'h77, 2'd1);
        clk_en = 1'b0;
        for (int k = 0; k < 20; k++) drive(1'b1, 32'h99, 2'd2);
        tests++;
        if (m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL clken_freeze: got m_tvalid=%b want 0", m_tvalid);
        end
        clk_en = 1'b1;
        for (int k = 0; k < 7; k++) drive(1'b0, '0, 2'd0);
        tests++;
        if (m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL clken_early: got m_tvalid=%b want 0 after 7 idle", m_tvalid);
        end
        drive(1'b0, '0, 2'd0);
        tests++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== {1'b1, 32'h77, 2'd1, 1'b1}) begin
            fails++;
            $display("FAIL clken_flush: got v=%b d=%h u=%h l=%b want v=1 d=77 u=1 l=1",
                     m_tvalid, m_tdata, m_tuser, m_tlast);
        end
    endtask

    task automatic test_reset_mid_frame();
        word_t e;
        do_reset();
        drive(1'b1, 32'h11, 2'd0);
        drive(1'b1, 32'h22, 2'd0);
        s_tvalid = 1'b0;
        tests++;
        if (m_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_valid: got %b want 1", m_tvalid);
        end
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== '0) begin
            fails++;
            $display("FAIL rst_async: got v=%b d=%h u=%h l=%b want all 0",
                     m_tvalid, m_tdata, m_tuser, m_tlast);
        end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        m_tready = 1'b1;
        for (int k = 1; k <= 4; k++) drive(1'b1, 32'h30 + 32'(k), 2'd3);
        for (int k = 0; k < 12; k++) drive(1'b0, '0, 2'd0);
        tests++;
        if (got.size() != 4) begin
            fails++;
            $display("FAIL rst_burst_count: got %0d words want 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            e = {32'h31 + 32'(i), 2'd3, (i == 3)};
            tests++;
            if (i >= got.size() || got[i] !== e) begin
                fails++;
                $display("FAIL rst_burst_word[%0d]: got %h want %h", i,
                         (i < got.size()) ? got[i] : '0, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_user_change();
        test_timeout_latency();
        test_overflow();
        test_clr_err();
        test_clk_en();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
